// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave blocks: default word width, the
// slave state type, and the bit-counter sizing helper.
package spi_pkg;

   localparam int SPI_DATA_W_DEF = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_slv_state_t;

   // Ceiling log2, never less than 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/spi_tx_hold.sv
// One-entry transmit holding register: valid/ready write side, and a load
// port that empties the entry and reports whether it held a word.
module spi_tx_hold #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic              load,
   output logic [DATA_W-1:0] load_data,
   output logic              load_hit
);

   logic              ready_q;
   logic              ready_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   // A load sees the entry as it was before any write in the same cycle.
   always_comb begin
      ready_d = ready_q;
      data_d  = data_q;
      if (load && !ready_q) begin
         ready_d = 1'b1;
      end
      if (wr_valid && ready_q) begin
         ready_d = 1'b0;
         data_d  = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ready_q <= 1'b1;
         data_q  <= '0;
      end else begin
         ready_q <= ready_d;
         data_q  <= data_d;
      end
   end

   assign wr_ready  = ready_q;
   assign load_hit  = !ready_q;
   assign load_data = ready_q ? '0 : data_q;

endmodule

// File: rtl/spi_slave_shifter.sv
// Mode-0 SPI slave shift engine driven by pre-detected SCLK edge pulses:
// assembles receive words, serializes transmit words, flags aborts/underruns.
module spi_slave_shifter
   import spi_pkg::*;
#(
   parameter int DATA_W    = SPI_DATA_W_DEF,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk_rise,
   input  logic              sclk_fall,
   input  logic              cs_n,
   input  logic              mosi,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              miso,
   output logic              miso_oe,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              underrun,
   output logic              frame_abort
);

   localparam int             CNT_W    = clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   spi_slv_state_t    state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              underrun_q, underrun_d;
   logic              frame_abort_q, frame_abort_d;
   logic              busy_q, busy_d;
   logic              miso_q, miso_d;

   logic              hold_load;
   logic [DATA_W-1:0] hold_data;
   logic              hold_hit;
   logic [DATA_W-1:0] rx_next;

   spi_tx_hold #(
      .DATA_W(DATA_W)
   ) u_tx_hold (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (tx_data),
      .wr_valid (tx_valid),
      .wr_ready (tx_ready),
      .load     (hold_load),
      .load_data(hold_data),
      .load_hit (hold_hit)
   );

   // CS deassertion outranks any edge; a rise outranks a fall in the same cycle.
   always_comb begin
      rx_next       = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi}
                                : {mosi, rx_shift_q[DATA_W-1:1]};
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      tx_shift_d    = tx_shift_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      underrun_d    = 1'b0;
      frame_abort_d = 1'b0;
      hold_load     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!cs_n) begin
               state_d    = ACTIVE;
               hold_load  = 1'b1;
               tx_shift_d = hold_data;
               underrun_d = !hold_hit;
               bit_cnt_d  = '0;
               rx_shift_d = '0;
            end
         end
         ACTIVE: begin
            if (cs_n) begin
               state_d       = IDLE;
               frame_abort_d = (bit_cnt_q != '0);
               bit_cnt_d     = '0;
               rx_shift_d    = '0;
               tx_shift_d    = '0;
            end else if (sclk_rise) begin
               rx_shift_d = rx_next;
               if (bit_cnt_q == LAST_BIT) begin
                  rx_data_d  = rx_next;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (sclk_fall) begin
               if (bit_cnt_q == '0) begin
                  hold_load  = 1'b1;
                  tx_shift_d = hold_data;
                  underrun_d = !hold_hit;
               end else begin
                  tx_shift_d = MSB_FIRST ? {tx_shift_q[DATA_W-2:0], 1'b0}
                                         : {1'b0, tx_shift_q[DATA_W-1:1]};
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == ACTIVE);
      miso_d = busy_d && (MSB_FIRST ? tx_shift_d[DATA_W-1] : tx_shift_d[0]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         tx_shift_q    <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         underrun_q    <= 1'b0;
         frame_abort_q <= 1'b0;
         busy_q        <= 1'b0;
         miso_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         tx_shift_q    <= tx_shift_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         underrun_q    <= underrun_d;
         frame_abort_q <= frame_abort_d;
         busy_q        <= busy_d;
         miso_q        <= miso_d;
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = busy_q;
   assign busy        = busy_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign underrun    = underrun_q;
   assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed plus randomized frame-level bench for spi_slave_shifter, checked
// against a word/queue-level model of the slave's transmit and receive behaviour.
module tb_spi_slave_shifter;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              sclk_rise;
   logic              sclk_fall;
   logic              cs_n;
   logic              mosi;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              miso;
   logic              miso_oe;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
   logic              underrun;
   logic              frame_abort;

   int nAsserts = 0;
   int nFails   = 0;

   // Model: holding entry, word currently being sent, bits sent/received in
   // the current word, and the last word the slave should have reported.
   logic       holdFull;
   logic [7:0] holdVal;
   logic [7:0] curTx;
   logic [7:0] lastRx;
   int         bitCnt;

   spi_slave_shifter #(
      .DATA_W   (DATA_W),
      .MSB_FIRST(1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk_rise  (sclk_rise),
      .sclk_fall  (sclk_fall),
      .cs_n       (cs_n),
      .mosi       (mosi),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .miso       (miso),
      .miso_oe    (miso_oe),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .busy       (busy),
      .underrun   (underrun),
      .frame_abort(frame_abort)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one cycle of inputs; pulses drop again after the clock edge.
   task automatic applyStimulus(input logic rise, input logic fall, input logic cs,
                                input logic m, input logic v, input logic [7:0] d);
      sclk_rise = rise;
      sclk_fall = fall;
      cs_n      = cs;
      mosi      = m;
      tx_valid  = v;
      tx_data   = d;
      @(negedge clk);
      sclk_rise = 1'b0;
      sclk_fall = 1'b0;
      tx_valid  = 1'b0;
   endtask

   task automatic modelLoad(output logic und);
      if (holdFull) begin
         curTx    = holdVal;
         holdFull = 1'b0;
         und      = 1'b0;
      end else begin
         curTx = 8'h00;
         und   = 1'b1;
      end
   endtask

   task automatic writeTx(input logic [7:0] d);
      checkOutput("tx_ready_before_write", 32'(tx_ready), 32'(!holdFull));
      applyStimulus(1'b0, 1'b0, cs_n, mosi, 1'b1, d);
      if (!holdFull) begin
         holdFull = 1'b1;
         holdVal  = d;
      end
      checkOutput("tx_ready_after_write", 32'(tx_ready), 32'(!holdFull));
   endtask

   task automatic startFrame();
      logic und;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      modelLoad(und);
      bitCnt = 0;
      checkOutput("busy_at_cs_fall", 32'(busy), 32'd1);
      checkOutput("miso_oe_at_cs_fall", 32'(miso_oe), 32'd1);
      checkOutput("underrun_at_cs_fall", 32'(underrun), 32'(und));
      checkOutput("miso_first_bit", 32'(miso), 32'(curTx[7]));
      step(2);
      checkOutput("underrun_one_cycle", 32'(underrun), 32'd0);
   endtask

   // Shift nbits of w (MSB first), each as a rise then a fall, optionally
   // writing wrData in the same cycle as the final fall.
   task automatic shiftBits(input logic [7:0] w, input int nbits,
                            input bit wrOnLast, input logic [7:0] wrData);
      logic und;
      logic preFull;
      bit   wordDone;
      bit   wr;
      for (int i = 0; i < nbits; i++) begin
         checkOutput("miso_before_rise", 32'(miso), 32'(curTx[7-bitCnt]));
         applyStimulus(1'b1, 1'b0, 1'b0, w[7-i], 1'b0, 8'h00);
         wordDone = (bitCnt == 7);
         bitCnt   = wordDone ? 0 : bitCnt + 1;
         if (wordDone) lastRx = w;
         checkOutput("rx_valid_after_rise", 32'(rx_valid), 32'(wordDone));
         checkOutput("rx_data_after_rise", 32'(rx_data), 32'(lastRx));
         checkOutput("underrun_after_rise", 32'(underrun), 32'd0);
         step(2);
         wr      = wrOnLast && (i == nbits - 1);
         preFull = holdFull;
         applyStimulus(1'b0, 1'b1, 1'b0, mosi, wr, wrData);
         if (bitCnt == 0) modelLoad(und);
         else und = 1'b0;
         if (wr && !preFull) begin
            holdFull = 1'b1;
            holdVal  = wrData;
         end
         checkOutput("underrun_after_fall", 32'(underrun), 32'(und));
         checkOutput("rx_valid_after_fall", 32'(rx_valid), 32'd0);
         checkOutput("miso_after_fall", 32'(miso), 32'(curTx[7-bitCnt]));
         step(2);
      end
   endtask

   task automatic endFrame(input logic riseToo);
      logic expAbort;
      expAbort = (bitCnt != 0);
      applyStimulus(riseToo, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      bitCnt = 0;
      checkOutput("frame_abort", 32'(frame_abort), 32'(expAbort));
      checkOutput("busy_after_cs_rise", 32'(busy), 32'd0);
      checkOutput("miso_oe_after_cs_rise", 32'(miso_oe), 32'd0);
      checkOutput("rx_valid_at_cs_rise", 32'(rx_valid), 32'd0);
      checkOutput("rx_data_held", 32'(rx_data), 32'(lastRx));
      step(1);
      checkOutput("frame_abort_one_cycle", 32'(frame_abort), 32'd0);
      step(2);
   endtask

   initial begin
      logic [7:0] w;
      int         nWords;
      rst       = 1'b0;
      sclk_rise = 1'b0;
      sclk_fall = 1'b0;
      cs_n      = 1'b0;
      mosi      = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      holdFull  = 1'b0;
      holdVal   = 8'h00;
      curTx     = 8'h00;
      lastRx    = 8'h00;
      bitCnt    = 0;

      $display("[TB] reset with cs_n low");
      step(3);
      checkOutput("rst_miso", 32'(miso), 32'd0);
      checkOutput("rst_miso_oe", 32'(miso_oe), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
      checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
      checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("rst_underrun", 32'(underrun), 32'd0);
      checkOutput("rst_frame_abort", 32'(frame_abort), 32'd0);
      cs_n = 1'b1;
      rst  = 1'b1;
      step(2);

      $display("[TB] single word");
      writeTx(8'hA5);
      startFrame();
      shiftBits(8'h3C, 8, 1'b0, 8'h00);
      endFrame(1'b0);

      $display("[TB] back-to-back words");
      writeTx(8'h11);
      startFrame();
      writeTx(8'h22);
      shiftBits(8'hF0, 8, 1'b0, 8'h00);
      shiftBits(8'h0F, 8, 1'b0, 8'h00);
      endFrame(1'b0);

      $display("[TB] underrun at cs fall");
      startFrame();
      shiftBits(8'h96, 8, 1'b0, 8'h00);
      endFrame(1'b0);

      $display("[TB] abort after five rises");
      writeTx(8'h5A);
      startFrame();
      shiftBits(8'hC3, 5, 1'b0, 8'h00);
      endFrame(1'b0);

      $display("[TB] collision of write and reload");
      writeTx(8'h77);
      startFrame();
      shiftBits(8'h12, 8, 1'b1, 8'h99);
      shiftBits(8'h34, 8, 1'b0, 8'h00);
      shiftBits(8'h56, 8, 1'b0, 8'h00);
      endFrame(1'b0);

      $display("[TB] cs rise together with final rise");
      writeTx(8'hE1);
      startFrame();
      shiftBits(8'hBD, 7, 1'b0, 8'h00);
      endFrame(1'b1);

      $display("[TB] reset mid-frame");
      writeTx(8'h3E);
      startFrame();
      shiftBits(8'h81, 3, 1'b0, 8'h00);
      writeTx(8'h42);
      rst  = 1'b0;
      cs_n = 1'b1;
      step(1);
      holdFull = 1'b0;
      lastRx   = 8'h00;
      bitCnt   = 0;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_tx_ready", 32'(tx_ready), 32'd1);
      checkOutput("midrst_rx_data", 32'(rx_data), 32'd0);
      checkOutput("midrst_miso_oe", 32'(miso_oe), 32'd0);
      rst = 1'b1;
      step(2);

      $display("[TB] randomized frames");
      for (int f = 0; f < 8; f++) begin
         if ($urandom_range(1, 0) == 1) writeTx(8'($urandom));
         startFrame();
         nWords = $urandom_range(3, 1);
         for (int k = 0; k < nWords; k++) begin
            w = 8'($urandom);
            shiftBits(w, 8, bit'($urandom_range(1, 0)), 8'($urandom));
         end
         if ($urandom_range(1, 0) == 1) begin
            w = 8'($urandom);
            shiftBits(w, $urandom_range(7, 1), 1'b0, 8'h00);
         end
         endFrame(logic'($urandom_range(1, 0)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/spi_slave_shifter.md
# spi_slave_shifter

Mode-0 (CPOL=0, CPHA=0) SPI slave shift engine consuming single-cycle SCLK edge pulses and synchronized CS/MOSI levels from the SPI edge-detection front end. It assembles received words, serializes transmit words from a one-entry holding register, and flags frame aborts and transmit underruns. The block is the loopback/test target for the SPI master on the same FPGA and runs entirely in the `clk` domain.

## Interface
- `DATA_W`, 8: word length in bits; legal range 4..32.
- `MSB_FIRST`, 1: 1 = MSB shifted first on MOSI/MISO, 0 = LSB first.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `sclk_rise`  in  1  one-cycle pulse per SCLK rising edge, from the edge detector.
- `sclk_fall`  in  1  one-cycle pulse per SCLK falling edge.
- `cs_n`  in  1  synchronized chip select, delay-aligned with the edge pulses.
- `mosi`  in  1  synchronized MOSI, delay-aligned with the edge pulses.
- `tx_data`  in  DATA_W  next word to transmit.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  holding register empty; a write occurs when `tx_valid & tx_ready`.
- `miso`  out  1  serial output data.
- `miso_oe`  out  1  MISO output enable; high only while the frame is active.
- `rx_data`  out  DATA_W  last complete received word; held until the next word completes.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  frame active (state ACTIVE).
- `underrun`  out  1  one-cycle pulse when a word load finds the holding register empty.
- `frame_abort`  out  1  one-cycle pulse when CS deasserts with a partial word (bit count ≠ 0).

## Operation
- States: IDLE and ACTIVE.
- IDLE → ACTIVE when a sampled `cs_n` is 0.
  - On entry, load `tx_shift` from the holding register and mark the holding register empty.
  - If the holding register is empty, load all-zeros and pulse `underrun`.
  - Clear `bit_cnt` to 0.
- In ACTIVE:
  - **`sclk_rise`:** shift `mosi` into `rx_shift` and increment `bit_cnt`.
    - At `bit_cnt == DATA_W-1`, write `rx_data` with the completed word, pulse `rx_valid`, and wrap `bit_cnt` to 0.
  - **`sclk_fall`:** shift `tx_shift` by one bit.
    - If `bit_cnt == 0` (word boundary, after the last bit), reload `tx_shift` from the holding register instead, with the same underrun rule as on entry.
- `miso` is the current first-out bit of `tx_shift`: bit DATA_W-1 if `MSB_FIRST`, else bit 0. `miso_oe` = `busy`.
- ACTIVE → IDLE on `cs_n` = 1, from any bit position.
  - If `bit_cnt` ≠ 0: pulse `frame_abort`, discard `rx_shift`, no `rx_valid`.
  - `tx_shift` contents are discarded; the holding register is unaffected.
- Holding register: one entry, written on `tx_valid & tx_ready`; `tx_ready` = ~full. Writable in both states.
- Edges in IDLE are ignored.
- Simultaneous events:
  - `sclk_rise` and `sclk_fall` in the same cycle: rise is processed, fall is dropped.
  - CS-fall cycle carrying an edge pulse: the edge is ignored.
  - Holding-register write in the same cycle as a load: the load sees the pre-write state, i.e. empty → zeros + `underrun`. The write lands, and `tx_ready` drops next cycle.
  - `cs_n` = 1 together with a final `sclk_rise`: abort wins, no `rx_valid`.

## Timing
- All outputs are registered.
- Reset values: `miso` 0, `miso_oe` 0, `busy` 0, `tx_ready` 1, `rx_data` 0, `rx_valid` 0, `underrun` 0, `frame_abort` 0; state IDLE, `bit_cnt` 0, holding register empty.
- Reset mid-frame returns to the reset values immediately; a frame already in progress is not resumed.
- `rx_valid` is high in the cycle after the clock that samples the final `sclk_rise`.
- `miso` changes one `clk` after `sclk_fall` (or after the CS-fall sample for the first bit).
- The master must leave at least 3 `clk` cycles between CS fall and the first SCLK rise, and between SCLK edges. The SCLK period is therefore at least 6 `clk`.
- Throughput: back-to-back words with no gap. The next word must be written before the last `sclk_fall` of the current word to avoid `underrun`.

## Structure
- Shared package `spi_pkg`:
  - `SPI_DATA_W_DEF` = 8;
  - state enum `spi_slv_state_t` {IDLE, ACTIVE};
  - bit-counter width function `clog2(DATA_W)`.
- One natural sub-module: `spi_tx_hold`, the one-entry valid/ready holding register with load/consume port. Everything else stays in the top module.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles with `cs_n` = 0 → all outputs at reset values, `tx_ready` = 1.
- **Single word:** write 0xA5; CS low; 8 SCLK cycles, MOSI = 0x3C (MSB first) → MISO bits 1,0,1,0,0,1,0,1; `rx_data` = 0x3C; `rx_valid` one pulse; no `underrun`.
- **Back-to-back:** write 0x11, and 0x22 during the first word; 16 SCLK cycles, MOSI 0xF0 then 0x0F → `rx_valid` twice with 0xF0 then 0x0F; MISO carries 0x11 then 0x22.
- **Underrun:** CS low with the holding register empty → `underrun` pulse at CS fall, MISO all zeros; the received word is still captured correctly.
- **Abort:** CS high after 5 SCLK rises → `frame_abort` pulse, no `rx_valid`, `rx_data` unchanged, `busy` 0 the next cycle.
- **Collision:** `tx_valid` in the same cycle as the reload `sclk_fall` with the holding register empty → `underrun` pulse; the word is held and sent in the following word.
